// File: rtl/avalon_mm_csr_bank.sv
// avalon_mm_csr_bank
// Avalon-MM slave register bank with byte enables, programmable write wait
// states, fixed-latency pipelined reads bounded by an outstanding-read limit,
// per-register read-only slots fed from hw_i, and a sticky protocol-error flag.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   avs_address           word address
//   avs_write/_writedata  write request and data
//   avs_byteenable        byte lanes to update on a write
//   avs_read              read request
//   avs_waitrequest       request must be held while high
//   avs_readdata/_valid   read return, READ_LATENCY cycles after acceptance
//   hw_i                  status words for read-only slots (slot i at [i*DWIDTH +: DWIDTH])
//   regs_o                read-write register contents (read-only slots drive 0)
//   protocol_err_o        sticky, cleared only by reset
module avalon_mm_csr_bank #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 4,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 2,
    parameter int WR_WAIT      = 1,
    parameter logic [2**AWIDTH-1:0] RO_MASK = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [AWIDTH-1:0]             avs_address,
    input  logic                          avs_write,
    input  logic [DWIDTH-1:0]             avs_writedata,
    input  logic [DWIDTH/8-1:0]           avs_byteenable,
    input  logic                          avs_read,
    output logic                          avs_waitrequest,
    output logic [DWIDTH-1:0]             avs_readdata,
    output logic                          avs_readdatavalid,
    input  logic [(2**AWIDTH)*DWIDTH-1:0] hw_i,
    output logic [(2**AWIDTH)*DWIDTH-1:0] regs_o,
    output logic                          protocol_err_o
);
    localparam int NREGS  = 2**AWIDTH;
    localparam int NBYTES = DWIDTH/8;
    localparam int PW     = $clog2(MAX_PENDING+1);
    localparam logic [3:0] WAIT_LOAD = (WR_WAIT > 0) ? 4'(WR_WAIT-1) : 4'd0;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_ACK} wstate_t;

    wstate_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic wr_commit, wr_wait, err_set;

    logic [DWIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0][DWIDTH-1:0] hw_w;
    logic [PW-1:0] pending;
    logic rd_slot, rd_accept;
    logic [DWIDTH-1:0] rd_word;

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [DWIDTH-1:0] dat_pipe [READ_LATENCY];

    assign hw_w = hw_i;

    // Write FSM. The W_IDLE cycle that first sees write counts as the first
    // wait cycle, so the counter only covers the remaining WR_WAIT-1 cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= W_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_commit = 1'b0;
        wr_wait   = 1'b0;
        err_set   = avs_read & avs_write;
        case (state)
            W_IDLE: begin
                if (avs_write) begin
                    if (WR_WAIT == 0) begin
                        wr_commit = 1'b1;
                    end else begin
                        wr_wait   = 1'b1;
                        cnt_nxt   = WAIT_LOAD;
                        state_nxt = (WR_WAIT == 1) ? W_ACK : W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (!avs_write) begin
                    // master abandoned a stalled write
                    state_nxt = W_IDLE;
                    err_set   = 1'b1;
                end else begin
                    wr_wait = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = W_ACK;
                end
            end
            W_ACK: begin
                state_nxt = W_IDLE;
                if (avs_write) wr_commit = 1'b1;
                else           err_set   = 1'b1;
            end
            default: state_nxt = W_IDLE;
        endcase
    end

    // A return this cycle frees its slot for an acceptance in the same cycle.
    assign rd_slot   = (pending < PW'(MAX_PENDING)) | avs_readdatavalid;
    assign rd_accept = avs_read & ~avs_write & rd_slot;
    assign avs_waitrequest = avs_write ? wr_wait : (avs_read & ~rd_slot);
    assign rd_word = RO_MASK[avs_address] ? hw_w[avs_address] : regs[avs_address];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NREGS; i++)
                for (int b = 0; b < NBYTES; b++)
                    if (!RO_MASK[i] && avs_address == AWIDTH'(i) && avs_byteenable[b])
                        regs[i][b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_regs_o
        assign regs_o[i*DWIDTH +: DWIDTH] = RO_MASK[i] ? '0 : regs[i];
    end

    // Data stages only advance behind a valid bit, so the last stage holds the
    // most recent return while readdatavalid is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_accept;
            if (rd_accept) dat_pipe[0] <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign avs_readdatavalid = vld_pipe[READ_LATENCY-1];
    assign avs_readdata      = dat_pipe[READ_LATENCY-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending        <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            case ({rd_accept, avs_readdatavalid})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
            if (err_set) protocol_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avalon_mm_csr_bank.sv
// Bench for avalon_mm_csr_bank: two instances with different wait/pending/RO
// settings, a table of write/read-back vectors, hand sequences for flow
// control, protocol errors and reset, then random traffic against a word-array
// model of the bank and a queue of expected read returns.
module tb_avalon_mm_csr_bank;
    localparam int DW = 32, AW = 4, NR = 16, L = 2;
    localparam int WW0 = 1, WW1 = 3;
    localparam int MP0 = 2, MP1 = 1;
    localparam logic [NR-1:0] RO0 = 16'h0220;
    localparam logic [NR-1:0] RO1 = 16'h0000;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] write, read, wait_r, rvalid, err;
    logic [AW-1:0]    addr   [2];
    logic [DW-1:0]    wdata  [2];
    logic [DW-1:0]    rdata  [2];
    logic [DW/8-1:0]  be     [2];
    logic [NR*DW-1:0] hw     [2];
    logic [NR*DW-1:0] regs_o [2];

    avalon_mm_csr_bank #(.DWIDTH(DW), .AWIDTH(AW), .READ_LATENCY(L), .MAX_PENDING(MP0),
                         .WR_WAIT(WW0), .RO_MASK(RO0)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .avs_address(addr[0]), .avs_write(write[0]),
        .avs_writedata(wdata[0]), .avs_byteenable(be[0]), .avs_read(read[0]),
        .avs_waitrequest(wait_r[0]), .avs_readdata(rdata[0]), .avs_readdatavalid(rvalid[0]),
        .hw_i(hw[0]), .regs_o(regs_o[0]), .protocol_err_o(err[0]));

    avalon_mm_csr_bank #(.DWIDTH(DW), .AWIDTH(AW), .READ_LATENCY(L), .MAX_PENDING(MP1),
                         .WR_WAIT(WW1), .RO_MASK(RO1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .avs_address(addr[1]), .avs_write(write[1]),
        .avs_writedata(wdata[1]), .avs_byteenable(be[1]), .avs_read(read[1]),
        .avs_waitrequest(wait_r[1]), .avs_readdata(rdata[1]), .avs_readdatavalid(rvalid[1]),
        .hw_i(hw[1]), .regs_o(regs_o[1]), .protocol_err_o(err[1]));

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [2][NR];
    logic [DW-1:0] last [2];
    typedef struct { int d; logic [DW-1:0] data; int ret; } exp_t;
    exp_t q[$];

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic int wwf(int d); return d == 0 ? WW0 : WW1; endfunction
    function automatic int mpf(int d); return d == 0 ? MP0 : MP1; endfunction
    function automatic bit ro(int d, logic [AW-1:0] a); return d == 0 ? RO0[a] : RO1[a]; endfunction
    function automatic logic [DW-1:0] expv(int d, logic [AW-1:0] a);
        return ro(d, a) ? hw[d][a*DW +: DW] : mem[d][a];
    endfunction
    // slots held by reads that are not returning this cycle
    function automatic bit full(int d);
        int n = 0;
        foreach (q[i]) if (q[i].d == d && q[i].ret > cyc) n++;
        return n >= mpf(d);
    endfunction

    // Return monitor: in-order data, exact latency, no unexpected returns.
    int idx;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (rvalid[d]) begin
                    idx = -1;
                    foreach (q[i]) if (idx < 0 && q[i].d == d) idx = i;
                    if (idx < 0) chk($sformatf("unexpected_rvalid%0d", d), 1, 0);
                    else begin
                        chk($sformatf("rdata%0d", d), rdata[d], q[idx].data);
                        chk($sformatf("rlat%0d", d), cyc, q[idx].ret);
                        q.delete(idx);
                    end
                    last[d] = rdata[d];
                end
            end
        end
    end

    task automatic wr(int d, logic [AW-1:0] a, logic [DW-1:0] dat, logic [3:0] b, bit with_rd = 0);
        int waits = 0;
        bit done = 0;
        addr[d] = a; wdata[d] = dat; be[d] = b; write[d] = 1'b1;
        if (with_rd) read[d] = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (wait_r[d]) waits++; else done = 1;
        end
        chk("wr_accept", done, 1);
        chk("wr_waits", waits, wwf(d));
        @(posedge clk); #1;
        if (done && !ro(d, a))
            for (int k = 0; k < 4; k++) if (b[k]) mem[d][a][k*8 +: 8] = dat[k*8 +: 8];
        write[d] = 1'b0; read[d] = 1'b0;
    endtask

    // Leaves read asserted so callers can chain back-to-back reads.
    task automatic rd(int d, logic [AW-1:0] a);
        bit done = 0;
        addr[d] = a; read[d] = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            chk("rd_wait", wait_r[d], full(d));
            if (!wait_r[d]) begin
                q.push_back('{d: d, data: expv(d, a), ret: cyc + L});
                done = 1;
            end
        end
        chk("rd_accept", done, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    typedef struct {
        int d; logic [AW-1:0] a; logic [DW-1:0] dat; logic [3:0] b;
        logic [DW-1:0] exp_rd; logic [DW-1:0] exp_reg;
    } vec_t;
    vec_t tbl [6];

    logic [3:0] pat;
    int a4, start;

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        write = '0; read = '0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdata[d] = '0; be[d] = '0; last[d] = '0;
            for (int i = 0; i < NR; i++) begin
                mem[d][i] = '0;
                hw[d][i*DW +: DW] = $urandom;
            end
        end
        hw[0][5*DW +: DW] = 32'hDEAD_BEEF;

        tbl[0] = '{0, 4'd3, 32'hA5A5_1234, 4'b1111, 32'hA5A5_1234, 32'hA5A5_1234};
        tbl[1] = '{0, 4'd3, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_FF34, 32'hA5A5_FF34};
        tbl[2] = '{0, 4'd5, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[3] = '{1, 4'd7, 32'h1234_5678, 4'b1001, 32'h1200_0078, 32'h1200_0078};
        tbl[4] = '{1, 4'd7, 32'hABCD_EF01, 4'b0110, 32'h12CD_EF78, 32'h12CD_EF78};
        tbl[5] = '{0, 4'd0, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 32'h0000_0000};

        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rvalid", rvalid[d], 0);
            chk("rst_rdata", rdata[d], 0);
            chk("rst_err", err[d], 0);
            chk("rst_wait", wait_r[d], 0);
            chk("rst_regs", regs_o[d] == '0, 1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // all registers read back as zero after reset
        for (int a = 0; a < NR; a++) rd(1, AW'(a));
        read[1] = 1'b0;
        drain();

        for (int i = 0; i < 6; i++) begin
            wr(tbl[i].d, tbl[i].a, tbl[i].dat, tbl[i].b);
            rd(tbl[i].d, tbl[i].a);
            read[tbl[i].d] = 1'b0;
            drain();
            chk($sformatf("tbl%0d_rd", i), last[tbl[i].d], tbl[i].exp_rd);
            chk($sformatf("tbl%0d_reg", i), regs_o[tbl[i].d][tbl[i].a*DW +: DW], tbl[i].exp_reg);
        end

        // single outstanding read held continuously: accept every other cycle
        a4 = 0; addr[1] = '0; read[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat[k] = wait_r[1];
            if (!wait_r[1]) q.push_back('{d: 1, data: expv(1, AW'(a4)), ret: cyc + L});
            @(posedge clk); #1;
            if (!pat[k]) begin a4++; addr[1] = AW'(a4); end
        end
        read[1] = 1'b0;
        drain();
        chk("mp1_pattern", pat, 4'b1010);

        // two outstanding reads sustain one accept per cycle
        start = cyc;
        for (int a = 0; a < 6; a++) rd(0, AW'(a));
        read[0] = 1'b0;
        chk("b2b_cycles", cyc - start, 6);
        drain();

        // read and write together
        chk("perr0_pre", err[0], 0);
        wr(0, 4'd2, 32'hCAFE_F00D, 4'b1111, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("perr0_set", err[0], 1);
        rd(0, 4'd2);
        read[0] = 1'b0;
        drain();
        chk("perr0_rd", last[0], 32'hCAFE_F00D);
        chk("perr0_sticky", err[0], 1);

        // write abandoned mid-wait
        chk("perr1_pre", err[1], 0);
        addr[1] = 4'd4; wdata[1] = 32'h5555_AAAA; be[1] = 4'hF; write[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 write[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("perr1_set", err[1], 1);
        rd(1, 4'd4);
        read[1] = 1'b0;
        drain();
        chk("perr1_nowrite", last[1], 32'h0);

        // reset with two reads in flight and a stalled write
        addr[1] = 4'd8; wdata[1] = 32'h7777_7777; be[1] = 4'hF; write[1] = 1'b1;
        rd(0, 4'd1);
        addr[0] = 4'd6;
        @(negedge clk);
        chk("rst_b2b_accept", wait_r[0], 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rvalid", rvalid[0], 0);
        chk("arst_rdata", rdata[0], 0);
        chk("arst_err", err[0], 0);
        chk("arst_regs", regs_o[0] == '0, 1);
        chk("arst_err1", err[1], 0);
        q.delete();
        for (int d = 0; d < 2; d++) for (int i = 0; i < NR; i++) mem[d][i] = '0;
        read = '0; write = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rd(1, 4'd8);
        read[1] = 1'b0;
        drain();
        chk("arst_nowrite", last[1], 32'h0);

        // random traffic
        for (int it = 0; it < 150; it++) begin
            int d, n;
            d = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                wr(d, AW'($urandom), $urandom, 4'($urandom));
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) rd(d, AW'($urandom));
                read[d] = 1'b0;
            end
        end
        drain();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NR; i++)
                chk($sformatf("rand_regs%0d_%0d", d, i), regs_o[d][i*DW +: DW],
                    ro(d, AW'(i)) ? 32'h0 : mem[d][i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/avalon_mm_csr_bank.md
Name: avalon_mm_csr_bank

Overview:
- Parametrised Avalon-MM slave register bank. Successor to the fixed 32-bit/2-bit-address slave interface.
- Adds the following over that interface:
  - byteenable;
  - configurable write wait states;
  - pipelined reads with fixed latency and an outstanding-read limit;
  - per-register read-only mask;
  - sticky protocol-error flag.
- Sits between the Avalon-MM interconnect and datapath blocks, exposing control registers and sampling status inputs.

Parameters:
- DWIDTH, 32, data width in bits; must be a multiple of 8.
- AWIDTH, 4, word address width; the bank holds NREGS = 2**AWIDTH registers.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; range 1..8.
- MAX_PENDING, 2, maximum accepted reads not yet returned; range 1..READ_LATENCY.
- WR_WAIT, 1, cycles waitrequest is held high before a write is accepted; range 0..15.
- RO_MASK, 0, NREGS-bit mask. Bit i = 1 makes register i read-only and sourced from hw_i.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous active-low reset.
- avs_address  input  AWIDTH  word address.
- avs_write  input  1  write request.
- avs_writedata  input  DWIDTH  write data.
- avs_byteenable  input  DWIDTH/8  byte lane enables for writes.
- avs_read  input  1  read request.
- avs_waitrequest  output  1  slave not ready; request must be held.
- avs_readdata  output  DWIDTH  read data.
- avs_readdatavalid  output  1  readdata valid, one cycle per read.
- hw_i  input  NREGS*DWIDTH  status values for RO registers; register i uses bits [i*DWIDTH +: DWIDTH].
- regs_o  output  NREGS*DWIDTH  current values of RW registers; RO slots drive 0.
- protocol_err_o  output  1  sticky error flag.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; every register clears on reset assertion.
- Reset values:
  - all registers 0;
  - regs_o 0;
  - avs_readdata 0;
  - avs_readdatavalid 0;
  - protocol_err_o 0;
  - write wait counter 0;
  - pending counter 0;
  - read pipeline empty.
- avs_waitrequest is combinational from state and inputs. It is 0 while no request is present.
- Write path: states W_IDLE, W_WAIT, W_ACK.
  - W_IDLE with write=1: goes to W_WAIT and loads the counter with WR_WAIT-1. If WR_WAIT=0, goes straight to acceptance in the same cycle.
  - W_WAIT: waitrequest=1; the counter decrements; at 0 the FSM moves to W_ACK.
  - W_ACK: waitrequest=0. The write commits at this clock edge, then the FSM returns to W_IDLE.
  - So a write sees exactly WR_WAIT cycles of waitrequest=1, followed by one accept cycle.
- Write commit:
  - For each lane b with byteenable[b]=1, register[address] byte b takes writedata byte b.
  - Lanes with byteenable=0 keep their value.
  - Writes to RO registers are accepted with normal timing and discarded.
- Master drops write during W_WAIT: protocol violation. The FSM returns to W_IDLE, nothing is written, and protocol_err_o is set.
- Read acceptance: read=1, write=0, and pending < MAX_PENDING.
  - Accepting a read makes waitrequest 0 in that cycle.
  - If pending == MAX_PENDING, waitrequest=1 until a return frees a slot.
  - One read can be accepted per cycle (back-to-back).
- Read data:
  - Sampled at the acceptance edge: register value for RW, hw_i slice for RO.
  - Pushed into a READ_LATENCY-deep shift pipeline.
  - Appears on avs_readdata with avs_readdatavalid=1 exactly READ_LATENCY cycles after acceptance.
  - Returned in order. avs_readdata holds its last value when valid=0.
- Pending counter:
  - +1 on acceptance, -1 on a readdatavalid return.
  - Acceptance and return in the same cycle leave it unchanged; the freed slot is usable that cycle.
- Ordering: a read accepted the cycle after a write's accept cycle returns the new value.
- read=1 and write=1 together:
  - protocol_err_o is set;
  - the write is serviced;
  - waitrequest follows the write FSM;
  - the read is not accepted until write is deasserted.
- protocol_err_o is cleared only by reset.
- Reset asserted mid-operation:
  - in-flight reads are dropped, with no readdatavalid after reset;
  - a pending write does not commit.
- regs_o updates on the clock edge after commit.

Test Plan:
1. Reset, then read all NREGS (RO_MASK=0) -> every readdatavalid returns 0, each READ_LATENCY=2 cycles after its acceptance.
2. WR_WAIT=1: write addr 3 data 0xA5A5_1234, byteenable 4'b1111 -> waitrequest high 1 cycle then low 1 cycle. Then write 0xFFFF_FFFF with byteenable 4'b0010 -> read addr 3 returns 0xA5A5_FF34 and regs_o slice 3 = 0xA5A5_FF34.
3. RO_MASK bit 5 set, hw_i slice 5 = 0xDEAD_BEEF: write 0x0 to addr 5 -> accepted with normal timing; read returns 0xDEAD_BEEF; regs_o slice 5 = 0.
4. MAX_PENDING=1, READ_LATENCY=2: read held 4 cycles at addrs 0..3 -> waitrequest 0,1,0,1 pattern; readdatavalid pulses 2 cycles after each accept; data in order.
5. MAX_PENDING=2: back-to-back reads on 6 consecutive cycles -> one accept per cycle and 6 consecutive readdatavalid pulses; pending never exceeds 2.
6. read=1 and write=1 together -> protocol_err_o=1 and stays 1; write commits; no readdatavalid until read is re-issued alone. Assert rst_n_i with 2 reads in flight -> outputs 0 immediately and no later readdatavalid.
